md5_cracker_host: RTL and testbench
===================================

# md5_cracker_host

Command-side initiator for the MD5 brute-force engine's 32-bit word command port. On a single start request it programs the target digest and character range, starts the generator, waits for the match flag, and reads back the matching plaintext and, optionally, the candidate count. It sits between the board's control logic and the cracker core. It drives the core's `hasReceived` and `dataIn` inputs and consumes its `dataOut` and `hasMatched` outputs.

## Interface
- STROBE_CYCLES, 2: cycles `cmdStrobe` is held high per word; legal range 1-255.
- GAP_CYCLES, 4: low cycles after each strobe before the next word; the response is sampled on the last gap cycle; legal range 2-255.
- clk  in  1  system clock; the single clock domain.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request; ignored while `busy`=1.
- abort  in  1  honoured only in WAIT_MATCH.
- digest  in  128  target {A,B,C,D}; A=[127:96], D=[31:0]; latched on accepted `start`.
- minChar, maxChar  in  8 each  printable range; latched on accepted `start`.
- cmdWord  out  32  drives the core's `dataIn`.
- cmdStrobe  out  1  drives the core's `hasReceived`; the core acts on its rising edge.
- respWord  in  32  the core's `dataOut`.
- matched  in  1  the core's `hasMatched`.
- busy  out  1  high from the cycle after `start` acceptance until the `done` cycle.
- done  out  1  one-cycle pulse at sequence end.
- found  out  1  1 = match read back; 0 = aborted; valid from `done` until the next `start`.
- text  out  96  plaintext words: [31:0]=TextChar1, [63:32]=TextChar2, [95:64]=TextChar3.
- count  out  64  candidate count; present only with the macro.

## Operation
- States: IDLE, STROBE, GAP, WAIT_MATCH, DONE. A word index selects `cmdWord` from a fixed program.
- Programming list, 12 words:
  - 0x52300000 ResetGenerator
  - 0x52301000, digest[127:96]
  - 0x52301001, digest[95:64]
  - 0x52301002, digest[63:32]
  - 0x52301003, digest[31:0]
  - 0x52302000, {16'h0, maxChar, minChar}
  - 0x52300001 StartGenerator
- Each word takes STROBE for STROBE_CYCLES, then GAP for GAP_CYCLES. `cmdWord` is stable through both phases.
- After the last programming word the block enters WAIT_MATCH.
  - `matched` is ignored before this point, so a stale flag from a previous run cannot complete the sequence.
- WAIT_MATCH with `matched`=1: send the readback list 0x44000001, 0x44000002, 0x44000003.
  - `respWord` is captured on the last GAP cycle of each word into `text` word 0, 1, 2.
  - Then DONE, with `found`=1.
- WAIT_MATCH with `abort`=1 and `matched`=0: send a single 0x52300000, then DONE with `found`=0.
  - `text` and `count` stay 0.
- `matched` and `abort` both high in the same cycle: `matched` wins.
- DONE lasts one cycle: `done`=1, `busy`=0 on the next cycle, return to IDLE.
- Accepted `start`: clears `text`, `count` and `found` on the next edge.
- `reset` asserted in any state, including mid-strobe:
  - Next edge gives IDLE, `cmdStrobe`=0, `cmdWord`=0.
  - The core's controller state is not recovered. The next run's first word is ResetGenerator, which is harmless in the core's Waiting state.
- Reset values: `cmdWord`=0, `cmdStrobe`=0, `busy`=0, `done`=0, `found`=0, `text`=0, `count`=0.

## Timing
- Let W = STROBE_CYCLES + GAP_CYCLES; defaults give W=6.
- `start` sampled at edge 0:
  - `busy`=1 and word 0 strobe high from edge 1.
  - Word k strobe rises at edge 1 + k·W.
- WAIT_MATCH is entered at edge 1 + 12W, which is edge 73 at defaults.
- `matched` sampled high at edge m: first readback strobe at m+1.
  - `done` at m + 1 + 3W; m+19 at defaults.
  - With the macro: m + 1 + 5W.
- Abort sampled at edge m: `done` at m + 1 + W.
- The strobe returns low for at least 2 cycles between words, so every word produces a distinct rising edge.

## Configuration
- MD5_HOST_COUNT_READ_EN defined:
  - The readback list appends 0x52303000 and 0x52303001, captured into `count[31:0]` and `count[63:32]`.
  - The `count` port exists.
- MD5_HOST_COUNT_READ_EN undefined:
  - Readback is 3 words and the `count` port is absent.
  - All other behaviour is identical.

## Test plan
- Defaults, digest=0x2971bc83_9b41f6a4_955620c0_9067fbfd, min=0x61, max=0x7a, `start` at edge 0 -> 12 words in listed order, strobe rises at edges 1, 7, …, 67; range word = 0x00007a61.
- Model asserts `matched` at edge 100 and returns 0x64636261, 0x68676665, 0x00006a69 -> `text`=0x00006a69_68676665_64636261, `found`=1, `done` at edge 119.
- `matched` held high from edge 0 (stale) -> no readback before edge 73; the programming sequence is unaltered.
- `abort` at edge 90 with `matched`=0 -> one 0x52300000 word, `done` at edge 97, `found`=0, `text`=0; `start` while busy is ignored.
- `reset` during word 3 strobe -> next edge gives `cmdStrobe`=0, `busy`=0, outputs 0; a new `start` replays from word 0.
- Macro defined, count responses 0x00001234 then 0x00000001 -> `count`=0x00000001_00001234, `done` at edge m+31.

Source files
------------

// File: rtl/md5_cracker_host.sv
// rtl/md5_cracker_host.sv - word-command initiator that programs, starts and reads back the MD5 cracker core
// Optional candidate-count readback is enabled by defining MD5_HOST_COUNT_READ_EN.
module md5_cracker_host #(
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] digest,
  input  logic [7:0]   minChar,
  input  logic [7:0]   maxChar,
  output logic [31:0]  cmdWord,
  output logic         cmdStrobe,
  input  logic [31:0]  respWord,
  input  logic         matched,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [95:0]  text
`ifdef MD5_HOST_COUNT_READ_EN
  ,
  output logic [63:0]  count
`endif
);

  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] GAP_LAST    = 8'(GAP_CYCLES - 1);
  localparam logic [3:0] PROG_LAST   = 4'd11;
`ifdef MD5_HOST_COUNT_READ_EN
  localparam logic [3:0] READ_LAST   = 4'd4;
`else
  localparam logic [3:0] READ_LAST   = 4'd2;
`endif

  typedef enum logic [2:0] {
    IDLE,
    STROBE,
    GAP,
    WAIT_MATCH,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_PROG,
    PH_READ,
    PH_ABORT
  } phase_t;

  state_t       state_q, state_d;
  phase_t       phase_q, phase_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [3:0]   widx_q, widx_d;
  logic [3:0]   last_idx;
  logic         accept;
  logic         capture;
  logic         set_found;

  logic [127:0] digest_q;
  logic [7:0]   min_q;
  logic [7:0]   max_q;
  logic [31:0]  prog_word;
  logic [31:0]  read_word;
  logic [31:0]  cur_word;

  // Programming list: each register address is followed by its data word.
  always_comb begin
    prog_word = 32'h0;
    case (widx_q)
      4'd0:    prog_word = 32'h5230_0000;
      4'd1:    prog_word = 32'h5230_1000;
      4'd2:    prog_word = digest_q[127:96];
      4'd3:    prog_word = 32'h5230_1001;
      4'd4:    prog_word = digest_q[95:64];
      4'd5:    prog_word = 32'h5230_1002;
      4'd6:    prog_word = digest_q[63:32];
      4'd7:    prog_word = 32'h5230_1003;
      4'd8:    prog_word = digest_q[31:0];
      4'd9:    prog_word = 32'h5230_2000;
      4'd10:   prog_word = {16'h0, max_q, min_q};
      4'd11:   prog_word = 32'h5230_0001;
      default: prog_word = 32'h0;
    endcase
  end

  always_comb begin
    read_word = 32'h0;
    case (widx_q)
      4'd0:    read_word = 32'h4400_0001;
      4'd1:    read_word = 32'h4400_0002;
      4'd2:    read_word = 32'h4400_0003;
      4'd3:    read_word = 32'h5230_3000;
      4'd4:    read_word = 32'h5230_3001;
      default: read_word = 32'h0;
    endcase
  end

  always_comb begin
    cur_word = prog_word;
    last_idx = PROG_LAST;
    case (phase_q)
      PH_READ: begin
        cur_word = read_word;
        last_idx = READ_LAST;
      end
      PH_ABORT: begin
        cur_word = 32'h5230_0000;
        last_idx = 4'd0;
      end
      default: begin
        cur_word = prog_word;
        last_idx = PROG_LAST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= PH_PROG;
      cnt_q   <= 8'h0;
      widx_q  <= 4'h0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    widx_d    = widx_q;
    accept    = 1'b0;
    capture   = 1'b0;
    set_found = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = STROBE;
          phase_d = PH_PROG;
          widx_d  = 4'h0;
          cnt_d   = 8'h0;
        end
      end
      STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          state_d = GAP;
          cnt_d   = 8'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 8'h0;
          capture = (phase_q == PH_READ);
          if (widx_q == last_idx) begin
            if (phase_q == PH_PROG) begin
              state_d = WAIT_MATCH;
            end else begin
              state_d   = DONE;
              set_found = (phase_q == PH_READ);
            end
          end else begin
            widx_d  = widx_q + 4'd1;
            state_d = STROBE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_MATCH: begin
        // A match outranks a simultaneous abort.
        if (matched) begin
          phase_d = PH_READ;
          widx_d  = 4'h0;
          cnt_d   = 8'h0;
          state_d = STROBE;
        end else if (abort) begin
          phase_d = PH_ABORT;
          widx_d  = 4'h0;
          cnt_d   = 8'h0;
          state_d = STROBE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmdStrobe = (state_q == STROBE);
  assign cmdWord   = (state_q == STROBE || state_q == GAP) ? cur_word : 32'h0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      digest_q <= 128'h0;
      min_q    <= 8'h0;
      max_q    <= 8'h0;
      text     <= 96'h0;
      found    <= 1'b0;
`ifdef MD5_HOST_COUNT_READ_EN
      count    <= 64'h0;
`endif
    end else begin
      if (accept) begin
        digest_q <= digest;
        min_q    <= minChar;
        max_q    <= maxChar;
        text     <= 96'h0;
        found    <= 1'b0;
`ifdef MD5_HOST_COUNT_READ_EN
        count    <= 64'h0;
`endif
      end
      if (capture) begin
        case (widx_q)
          4'd0:    text[31:0]   <= respWord;
          4'd1:    text[63:32]  <= respWord;
          4'd2:    text[95:64]  <= respWord;
`ifdef MD5_HOST_COUNT_READ_EN
          4'd3:    count[31:0]  <= respWord;
          4'd4:    count[63:32] <= respWord;
`endif
          default: ;
        endcase
      end
      if (set_found) begin
        found <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_md5_cracker_host.sv
// tb/tb_md5_cracker_host.sv - randomized self-checking bench for md5_cracker_host
// Edge numbers are those at which a value is sampled; the start-sampling edge is edge 0.
module tb_md5_cracker_host;

  localparam int SC     = 2;
  localparam int GC     = 4;
  localparam int W      = SC + GC;
  localparam int PROG_N = 12;
  localparam int WAIT_E = 1 + PROG_N * W;
`ifdef MD5_HOST_COUNT_READ_EN
  localparam int READ_N = 5;
`else
  localparam int READ_N = 3;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         matched = 1'b0;
  logic [127:0] digest = '0;
  logic [7:0]   minChar = '0;
  logic [7:0]   maxChar = '0;
  logic [31:0]  cmdWord;
  logic         cmdStrobe;
  logic [31:0]  respWord;
  logic         busy;
  logic         done;
  logic         found;
  logic [95:0]  text;
`ifdef MD5_HOST_COUNT_READ_EN
  logic [63:0]  count;
`endif

  int total = 0;
  int bad = 0;
  int edges = 0;
  int s_edge = 0;
  logic strobe_prev = 1'b0;
  logic [31:0] wq[$];
  int          eq[$];
  logic [31:0] rsp_text[3];
  logic [63:0] rsp_count = '0;

  md5_cracker_host #(.STROBE_CYCLES(SC), .GAP_CYCLES(GC)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .digest(digest), .minChar(minChar), .maxChar(maxChar),
    .cmdWord(cmdWord), .cmdStrobe(cmdStrobe), .respWord(respWord),
    .matched(matched), .busy(busy), .done(done), .found(found),
    .text(text)
`ifdef MD5_HOST_COUNT_READ_EN
    , .count(count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  // Core model: answers readback commands from the planned plaintext/count.
  always_comb begin
    case (cmdWord)
      32'h4400_0001: respWord = rsp_text[0];
      32'h4400_0002: respWord = rsp_text[1];
      32'h4400_0003: respWord = rsp_text[2];
      32'h5230_3000: respWord = rsp_count[31:0];
      32'h5230_3001: respWord = rsp_count[63:32];
      default:       respWord = 32'hA5A5_5A5A;
    endcase
  end

  always @(negedge clk) begin
    if (cmdStrobe && !strobe_prev) begin
      wq.push_back(cmdWord);
      eq.push_back(edges - s_edge);
    end
    strobe_prev <= cmdStrobe;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_seq(input string nm, input logic [127:0] dg, input logic [7:0] mn,
                         input logic [7:0] mx, input bit use_abort, input int ev, input bit poke);
    logic [31:0] exp_w[$];
    int          exp_e[$];
    int m, nx, done_exp, rel, guard, base;
    exp_w.push_back(32'h5230_0000);
    exp_w.push_back(32'h5230_1000); exp_w.push_back(dg[127:96]);
    exp_w.push_back(32'h5230_1001); exp_w.push_back(dg[95:64]);
    exp_w.push_back(32'h5230_1002); exp_w.push_back(dg[63:32]);
    exp_w.push_back(32'h5230_1003); exp_w.push_back(dg[31:0]);
    exp_w.push_back(32'h5230_2000); exp_w.push_back({16'h0, mx, mn});
    exp_w.push_back(32'h5230_0001);
    for (int k = 0; k < PROG_N; k++) exp_e.push_back(1 + k * W);
    m = (ev > WAIT_E) ? ev : WAIT_E;
    if (use_abort) begin
      exp_w.push_back(32'h5230_0000);
      nx = 1;
    end else begin
      exp_w.push_back(32'h4400_0001);
      exp_w.push_back(32'h4400_0002);
      exp_w.push_back(32'h4400_0003);
      if (READ_N == 5) begin
        exp_w.push_back(32'h5230_3000);
        exp_w.push_back(32'h5230_3001);
      end
      nx = READ_N;
    end
    for (int j = 0; j < nx; j++) exp_e.push_back(m + 1 + j * W);
    done_exp = m + 1 + nx * W;

    digest = dg; minChar = mn; maxChar = mx;
    abort = 1'b0;
    matched = (!use_abort && ev == 0);
    @(negedge clk);
    s_edge = edges;
    base = wq.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy1"}, busy, 1'b1);
    chk({nm, "_found_clr"}, found, 1'b0);
    guard = 0;
    rel = edges - s_edge;
    while (guard < 600) begin
      rel = edges - s_edge;
      if (done) break;
      if (rel == ev && ev != 0) begin
        if (use_abort) abort = 1'b1;
        else matched = 1'b1;
      end
      if (poke && rel == 30) begin
        start = 1'b1;
        digest = ~dg;
        minChar = ~mn;
      end
      if (poke && rel == 31) start = 1'b0;
      @(negedge clk);
      guard++;
    end
    chk({nm, "_done_edge"}, rel, done_exp);
    chk({nm, "_found"}, found, !use_abort);
    chk({nm, "_text"}, text, use_abort ? 96'h0 : {rsp_text[2], rsp_text[1], rsp_text[0]});
`ifdef MD5_HOST_COUNT_READ_EN
    chk({nm, "_count"}, count, use_abort ? 64'h0 : rsp_count);
`endif
    @(negedge clk);
    chk({nm, "_busy_after"}, busy, 1'b0);
    chk({nm, "_done_pulse"}, done, 1'b0);
    matched = 1'b0;
    abort = 1'b0;
    digest = dg;
    chk({nm, "_nwords"}, wq.size() - base, exp_w.size());
    for (int i = 0; i < exp_w.size() && base + i < wq.size(); i++) begin
      chk($sformatf("%s_word%0d", nm, i), wq[base + i], exp_w[i]);
      chk($sformatf("%s_edge%0d", nm, i), eq[base + i], exp_e[i]);
    end
  endtask

  task automatic reset_mid_strobe(input logic [127:0] dg);
    int guard;
    digest = dg; minChar = 8'h30; maxChar = 8'h39;
    @(negedge clk);
    s_edge = edges;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (edges - s_edge != 20 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("rst_mid_strobe_high", cmdStrobe, 1'b1);
    chk("rst_mid_word3", cmdWord, 32'h5230_1001);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_strobe", cmdStrobe, 1'b0);
    chk("rst_word", cmdWord, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_text", text, 96'h0);
    reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_word", cmdWord, 32'h0);
    chk("reset_strobe", cmdStrobe, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_found", found, 1'b0);
    chk("reset_text", text, 96'h0);
`ifdef MD5_HOST_COUNT_READ_EN
    chk("reset_count", count, 64'h0);
`endif
    reset = 1'b0;

    rsp_text[0] = 32'h6463_6261;
    rsp_text[1] = 32'h6867_6665;
    rsp_text[2] = 32'h0000_6a69;
    rsp_count   = 64'h0000_0001_0000_1234;
    run_seq("plan", 128'h2971bc83_9b41f6a4_955620c0_9067fbfd, 8'h61, 8'h7a, 1'b0, 100, 1'b0);
    run_seq("stale", 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 8'h41, 8'h5a, 1'b0, 0, 1'b0);
    run_seq("abort", 128'hdead_beef_0000_1111_2222_3333_4444_5555, 8'h61, 8'h7a, 1'b1, 90, 1'b1);

    reset_mid_strobe(128'h1111_2222_3333_4444_5555_6666_7777_8888);
    run_seq("replay", 128'h1111_2222_3333_4444_5555_6666_7777_8888, 8'h30, 8'h39, 1'b1, 80, 1'b0);

    for (int it = 0; it < 6; it++) begin
      logic [127:0] dg;
      logic [7:0]   mn;
      logic [7:0]   mx;
      dg = {$urandom, $urandom, $urandom, $urandom};
      mn = 8'($urandom_range(32, 90));
      mx = mn + 8'($urandom_range(0, 36));
      for (int i = 0; i < 3; i++) rsp_text[i] = $urandom;
      rsp_count = {$urandom, $urandom};
      run_seq($sformatf("rnd%0d", it), dg, mn, mx, 1'($urandom_range(0, 1)),
              $urandom_range(60, 140), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
